// File: rtl/psum_accumulator.sv
// psum_accumulator: sums NUM_CHUNKS consecutive signed partial sums from the
// adder tree into one dot-product result. Valid/ready on both sides; the
// finished result sits in an output register until the consumer takes it.
// Optional build macro: ACC_SATURATE_EN (clamp on signed overflow, out_sat
// reports a clamped result). Without it, arithmetic wraps and out_sat is 0.
module psum_accumulator #(
   parameter int PARTIAL_SUM_BW = 20,
   parameter int ACC_BW         = 24,
   parameter int NUM_CHUNKS     = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             acc_clr,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic signed [PARTIAL_SUM_BW-1:0] in_psum,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic signed [ACC_BW-1:0]         out_acc,
   output logic                             out_sat
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]               state;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         eff_cnt;
   logic signed [ACC_BW-1:0] acc;
   logic signed [ACC_BW-1:0] in_sext;
   logic signed [ACC_BW-1:0] sum;
   logic                     first;
   logic                     last;
   logic                     accept;

`ifdef ACC_SATURATE_EN
   localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
   localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

   logic sticky;
   logic sum_sat;

   // Signed add that clamps to the representable range; MSB of the return
   // value flags that a clamp happened.
   function automatic logic [ACC_BW:0] sat_add(input logic signed [ACC_BW-1:0] a,
                                                input logic signed [ACC_BW-1:0] b);
      logic signed [ACC_BW-1:0] s;
      logic                     ovf;
      s   = a + b;
      ovf = (a[ACC_BW-1] == b[ACC_BW-1]) && (s[ACC_BW-1] != a[ACC_BW-1]);
      if (ovf) s = a[ACC_BW-1] ? ACC_MIN : ACC_MAX;
      return {ovf, s};
   endfunction
`else
   // Plain two's-complement add, wrapping modulo 2^ACC_BW.
   function automatic logic signed [ACC_BW-1:0] wrap_add(input logic signed [ACC_BW-1:0] a,
                                                          input logic signed [ACC_BW-1:0] b);
      return a + b;
   endfunction
`endif

   // Size cast of a signed operand sign-extends.
   assign in_sext  = ACC_BW'(in_psum);
   assign in_ready = (state == ST_ACCUM) || out_ready;
   assign accept   = in_valid && in_ready;

   // Next-sum datapath. A beat accepted while holding a result always opens
   // a fresh accumulation, so the chunk position is treated as zero there.
   always_comb begin
      eff_cnt = (state == ST_HOLD) ? '0 : cnt;
      first   = (eff_cnt == '0);
      last    = (eff_cnt == LAST_CNT);
      sum     = in_sext;
`ifdef ACC_SATURATE_EN
      sum_sat = 1'b0;
      if (!first) begin
         {sum_sat, sum} = sat_add(acc, in_sext);
         sum_sat        = sum_sat | sticky;
      end
`else
      if (!first) sum = wrap_add(acc, in_sext);
`endif
   end

   // Accumulation / hold control; clear has priority over any handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ACCUM;
         cnt       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_acc   <= '0;
`ifdef ACC_SATURATE_EN
         sticky    <= 1'b0;
         out_sat   <= 1'b0;
`endif
      end else if (acc_clr) begin
         state     <= ST_ACCUM;
         cnt       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
`ifdef ACC_SATURATE_EN
         sticky    <= 1'b0;
         out_sat   <= 1'b0;
`endif
      end else if (accept) begin
         if (last) begin
            out_acc   <= sum;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= ST_HOLD;
`ifdef ACC_SATURATE_EN
            out_sat   <= sum_sat;
`endif
         end else begin
            acc       <= sum;
            cnt       <= eff_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            state     <= ST_ACCUM;
`ifdef ACC_SATURATE_EN
            sticky    <= sum_sat;
`endif
         end
      end else if ((state == ST_HOLD) && out_ready) begin
         out_valid <= 1'b0;
         state     <= ST_ACCUM;
      end
   end

`ifndef ACC_SATURATE_EN
   assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: dut0 (ACC_BW=20, NUM_CHUNKS=2) covers the
// accumulate/backpressure/clear/overflow behaviour, dut1 (ACC_BW=24,
// NUM_CHUNKS=1) covers single-beat streaming. Reference models append
// accepted beats to lists and fold them with integer arithmetic.
module tb_psum_accumulator;

   localparam int PSW = 20;
   localparam int AW0 = 20;
   localparam int AW1 = 24;
   localparam int NC0 = 2;
   localparam int NC1 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                  clr0, v0, r0, ov0, or0, sat0;
   logic signed [PSW-1:0] d0;
   logic signed [AW0-1:0] acc0;

   logic                  clr1, v1, r1, ov1, or1, sat1;
   logic signed [PSW-1:0] d1;
   logic signed [AW1-1:0] acc1;

   int total = 0;
   int bad   = 0;

   psum_accumulator #(.PARTIAL_SUM_BW(PSW), .ACC_BW(AW0), .NUM_CHUNKS(NC0)) dut0 (
      .clk(clk), .rst_n(rst_n), .acc_clr(clr0), .in_valid(v0), .in_ready(r0),
      .in_psum(d0), .out_valid(ov0), .out_ready(or0), .out_acc(acc0), .out_sat(sat0));

   psum_accumulator #(.PARTIAL_SUM_BW(PSW), .ACC_BW(AW1), .NUM_CHUNKS(NC1)) dut1 (
      .clk(clk), .rst_n(rst_n), .acc_clr(clr1), .in_valid(v1), .in_ready(r1),
      .in_psum(d1), .out_valid(ov1), .out_ready(or1), .out_acc(acc1), .out_sat(sat1));

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Sum a list of beats into a w-bit signed result, wrapping or clamping
   // after every add; s reports whether any clamp happened.
   function automatic void fold(input int b[$], input int w, output longint r, output bit s);
      longint one = 1;
      longint mx  = (one <<< (w - 1)) - 1;
      longint mn  = -(one <<< (w - 1));
      r = b[0];
      s = 1'b0;
      for (int i = 1; i < b.size(); i++) begin
         r = r + b[i];
`ifdef ACC_SATURATE_EN
         if (r > mx) begin r = mx; s = 1'b1; end
         else if (r < mn) begin r = mn; s = 1'b1; end
`else
         r = r & ((one <<< w) - 1);
         if (r > mx) r = r - (one <<< w);
`endif
      end
   endfunction

   int     part0[$];
   longint q0[$];
   bit     qs0[$];
   int     part1[$];
   longint q1[$];
   bit     qs1[$];

   // dut0 reference: decide acceptance from the model's own notion of a
   // pending result, collect beats, push a finished result per NC0 beats.
   always @(negedge clk) begin
      bit     rdy;
      longint r;
      bit     s;
      if (!rst_n) begin
         part0.delete(); q0.delete(); qs0.delete();
      end else begin
         rdy = (q0.size() == 0) || or0;
         chk("in_ready0", r0, rdy);
         if (clr0) begin
            part0.delete(); q0.delete(); qs0.delete();
         end else if (v0 && rdy) begin
            part0.push_back(int'(d0));
            if (part0.size() == NC0) begin
               fold(part0, AW0, r, s);
               q0.push_back(r); qs0.push_back(s);
               part0.delete();
            end
         end
      end
   end

   // dut1 reference, same rules with one beat per result.
   always @(negedge clk) begin
      bit     rdy;
      longint r;
      bit     s;
      if (!rst_n) begin
         part1.delete(); q1.delete(); qs1.delete();
      end else begin
         rdy = (q1.size() == 0) || or1;
         chk("in_ready1", r1, rdy);
         if (clr1) begin
            part1.delete(); q1.delete(); qs1.delete();
         end else if (v1 && rdy) begin
            part1.push_back(int'(d1));
            if (part1.size() == NC1) begin
               fold(part1, AW1, r, s);
               q1.push_back(r); qs1.push_back(s);
               part1.delete();
            end
         end
      end
   end

   // dut0 monitor: every retired result must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && ov0 && or0) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected0: got result %0d expected none", acc0);
         end else begin
            chk("result0", acc0, q0.pop_front());
            chk("sat0", sat0, qs0.pop_front());
         end
      end
   end

   // dut1 monitor.
   always @(negedge clk) begin
      if (rst_n && ov1 && or1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected1: got result %0d expected none", acc1);
         end else begin
            chk("result1", acc1, q1.pop_front());
            chk("sat1", sat1, qs1.pop_front());
         end
      end
   end

   task automatic drive0(input bit v, input int d, input bit ordy, input bit clr);
      v0 = v; d0 = PSW'(d); or0 = ordy; clr0 = clr;
      @(posedge clk); #1;
   endtask

   task automatic drive1(input bit v, input int d, input bit ordy);
      v1 = v; d1 = PSW'(d); or1 = ordy;
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      v0 = 0; d0 = '0; or0 = 1; clr0 = 0;
      v1 = 0; d1 = '0; or1 = 1; clr1 = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst out_valid", ov0, 0);
      chk("rst out_acc", acc0, 0);
      chk("rst out_sat", sat0, 0);
      chk("rst in_ready", r0, 1);

      // basic pairs
      drive0(1, 100, 1, 0);
      chk("no early valid", ov0, 0);
      drive0(1, -30, 1, 0);
      chk("latency valid", ov0, 1);
      chk("basic 70", acc0, 70);
      drive0(1, 5, 1, 0);
      drive0(1, 5, 1, 0);
      chk("basic 10", acc0, 10);
      drive0(0, 0, 1, 0);

      // backpressure
      drive0(1, 40, 1, 0);
      drive0(1, 30, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive0(1, 99, 0, 0);
         chk("bp in_ready", r0, 0);
         chk("bp hold acc", acc0, 70);
         chk("bp hold valid", ov0, 1);
      end
      drive0(1, 7, 1, 0);
      chk("bp retire", ov0, 0);
      drive0(1, 3, 1, 0);
      chk("bp new 10", acc0, 10);
      drive0(0, 0, 1, 0);

      // clear mid-accumulation, with a beat presented alongside the clear
      drive0(1, 50, 1, 0);
      drive0(1, 77, 1, 1);
      drive0(1, 1, 1, 0);
      drive0(1, 2, 1, 0);
      chk("clr then 3", acc0, 3);
      drive0(0, 0, 1, 0);

      // clear while a result is held
      drive0(1, 8, 1, 0);
      drive0(1, 9, 0, 0);
      chk("hold 17", acc0, 17);
      drive0(0, 0, 0, 1);
      chk("clr drops valid", ov0, 0);
      drive0(0, 0, 1, 0);
      chk("clr stays idle", ov0, 0);

      // overflow boundary
      drive0(1, 524287, 1, 0);
      drive0(1, 1, 1, 0);
`ifdef ACC_SATURATE_EN
      chk("ovf acc", acc0, 524287);
      chk("ovf sat", sat0, 1);
`else
      chk("ovf acc", acc0, -524288);
      chk("ovf sat", sat0, 0);
`endif
      drive0(1, -2, 1, 0);
      drive0(1, -3, 1, 0);
      chk("after ovf acc", acc0, -5);
      chk("after ovf sat", sat0, 0);
      drive0(0, 0, 1, 0);

      // random traffic on dut0; clear cycles keep out_ready low
      for (int i = 0; i < 300; i++) begin
         bit c;
         c = ($urandom_range(0, 29) == 0);
         drive0(1'($urandom_range(0, 1)), int'($urandom()),
                c ? 1'b0 : 1'($urandom_range(0, 1)), c);
      end
      repeat (3) drive0(0, 0, 1, 0);

      // reset in the middle of a beat while a result is held
      drive0(1, 40, 1, 0);
      drive0(1, 2, 0, 0);
      v0 = 1; d0 = 5; or0 = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst out_valid", ov0, 0);
      chk("mid rst out_acc", acc0, 0);
      chk("mid rst out_sat", sat0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; v0 = 0;
      #1;
      chk("post rst in_ready", r0, 1);
      chk("post rst valid", ov0, 0);
      drive0(0, 0, 1, 0);
      chk("post rst idle", ov0, 0);

      // single-beat streaming
      for (int i = 1; i <= 10; i++) begin
         drive1(1, i, 1);
         chk("stream valid", ov1, 1);
         chk("stream value", acc1, i);
      end
      drive1(0, 0, 1);
      for (int i = 0; i < 200; i++)
         drive1(1'($urandom_range(0, 1)), int'($urandom()), 1'($urandom_range(0, 1)));
      repeat (3) drive1(0, 0, 1);

      chk("q0 drained", q0.size(), 0);
      chk("q1 drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
